// File: rtl/plcpu_fetch_pkg.sv
// plcpu_fetch_pkg: shared constants and queue entry type for the fetch front end
package plcpu_fetch_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0084;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } fetch_entry_t;
endpackage

// File: rtl/plcpu_fetch_queue.sv
// plcpu_fetch_queue: DEPTH-entry FIFO of fetch entries with sync flush (flush beats push)
module plcpu_fetch_queue
  import plcpu_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [CW-1:0] count
);
  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rp, wp;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // pointer, occupancy and storage update; storage cleared on reset so the head reads zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= nxt(wp);
      end
      if (pop) rp <= nxt(rp);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign dout = mem[rp];
endmodule

// File: rtl/plcpu_fetch.sv
// plcpu_fetch: PC owner, imem request issue and decode-facing queue; IF_MISALIGN_CHK_EN enables misaligned-redirect trapping
module plcpu_fetch
  import plcpu_fetch_pkg::*;
#(
  parameter int          IMEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter int          QDEPTH     = 2,
  localparam int AW = $clog2(IMEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_en,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [31:0]   id_instr,
  output logic [31:0]   id_pc,
  output logic          id_misalign
);
  localparam int CW = $clog2(QDEPTH + 1);
  logic [31:0] pc_q, inflight_pc_q, tgt;
  logic inflight_q, halt_q, pend_q, mis, pop, push;
  logic [CW-1:0] count;
  fetch_entry_t head, wentry;
`ifdef IF_MISALIGN_CHK_EN
  assign tgt = redirect_pc;
  assign mis = redirect_pc[1:0] != 2'b00;
`else
  assign tgt = redirect_pc & ~32'h3;
  assign mis = 1'b0;
`endif
  // issue only when the queue plus the outstanding read leaves room after this cycle's pop
  always_comb begin
    pop = id_valid & id_ready;
    imem_en = rst & ~redirect_valid & ~halt_q & ((int'(count) + int'(inflight_q)) < (QDEPTH + int'(pop)));
    push = pend_q | inflight_q;
    wentry = pend_q ? fetch_entry_t'{pc: pc_q, instr: NOP_INSTR, misalign: 1'b1}
                    : fetch_entry_t'{pc: inflight_pc_q, instr: imem_rdata, misalign: 1'b0};
  end
  // PC, in-flight tracking and misaligned-redirect halt; redirect discards the outstanding read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      inflight_pc_q <= '0;
      halt_q <= 1'b0;
      pend_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q <= tgt;
      inflight_q <= 1'b0;
      halt_q <= mis;
      pend_q <= mis;
    end else begin
      pend_q <= 1'b0;
      inflight_q <= imem_en;
      if (imem_en) begin
        pc_q <= pc_q + 32'd4;
        inflight_pc_q <= pc_q;
      end
    end
  end
  plcpu_fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk  (clk),
    .rst  (rst),
    .flush(redirect_valid),
    .push (push),
    .pop  (pop),
    .din  (wentry),
    .dout (head),
    .count(count)
  );
  assign imem_addr = pc_q[AW+1:2];
  assign id_valid = count != '0;
  assign id_instr = head.instr;
  assign id_pc = head.pc;
  assign id_misalign = head.misalign;
endmodule

// File: tb/tb_plcpu_fetch.sv
// tb_plcpu_fetch: directed plus random stimulus checked against a PC-stream reference model
module tb_plcpu_fetch;
  import plcpu_fetch_pkg::*;
  localparam int AW = 10;
  localparam int QD = 2;
  localparam logic [31:0] RPC = 32'h0000_0084;
  logic clk = 1'b0;
  logic rst;
  logic imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_rdata;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
  logic id_misalign;
  logic [31:0] mem [1024];
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_pc, fpc;
  int outst;
  bit halt, exp_mis;
  logic o_en, o_valid, o_mis;
  logic [AW-1:0] o_addr;
  logic [31:0] o_pc, o_instr;

  plcpu_fetch #(.IMEM_WORDS(1024), .RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_valid(id_valid),
    .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc), .id_misalign(id_misalign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] fix(input logic [31:0] p);
`ifdef IF_MISALIGN_CHK_EN
    return p;
`else
    return p & ~32'h3;
`endif
  endfunction

  task automatic model_reset;
    exp_pc = RPC;
    fpc = RPC;
    outst = 0;
    halt = 0;
    exp_mis = 0;
  endtask

  task automatic chk_reset;
    chk("rst_en", imem_en, 0);
    chk("rst_addr", imem_addr, RPC[AW+1:2]);
    chk("rst_valid", id_valid, 0);
    chk("rst_pc", id_pc, 0);
    chk("rst_instr", id_instr, 0);
    chk("rst_mis", id_misalign, 0);
  endtask

  task automatic tick;
    logic pop;
    logic [31:0] t;
    #1;
    o_en = imem_en; o_addr = imem_addr; o_valid = id_valid;
    o_pc = id_pc; o_instr = id_instr; o_mis = id_misalign;
    pop = id_valid & id_ready;
    if (redirect_valid) chk("redirect_en", o_en, 0);
    if (halt && !redirect_valid) chk("halt_en", o_en, 0);
    if (halt && !exp_mis) chk("halt_valid", o_valid, 0);
    if (o_en) begin
      chk("addr", o_addr, fpc[AW+1:2]);
      fpc += 4;
    end
    if (pop) begin
      chk("pc", o_pc, exp_pc);
      chk("instr", o_instr, exp_mis ? NOP_INSTR : mem[exp_pc[AW+1:2]]);
      chk("misalign", o_mis, exp_mis);
      exp_pc += 4;
      exp_mis = 0;
    end
    outst += int'(o_en) - int'(pop);
    chk("occupancy", outst >= 0 && outst <= QD, 1);
    if (redirect_valid) begin
      t = fix(redirect_pc);
      exp_pc = t;
      fpc = t;
      halt = t[1:0] != 2'b00;
      exp_mis = halt;
      outst = halt ? 1 : 0;
    end
    @(negedge clk);
  endtask

  task automatic redir(input logic [31:0] p);
    redirect_valid = 1'b1;
    redirect_pc = p;
    tick;
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    rst = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    chk_reset;
    rst = 1'b1;
    model_reset;
    tick; chk("c0_en", o_en, 1); chk("c0_addr", o_addr, 32'h21);
    tick; chk("c1_valid", o_valid, 0);
    tick; chk("c2_valid", o_valid, 1); chk("c2_pc", o_pc, 32'h84);
    id_ready = 1'b0;
    repeat (5) begin tick; chk("bp_en", o_en, 0); end
    id_ready = 1'b1;
    repeat (10) begin tick; chk("tput_valid", o_valid, 1); end
    id_ready = 1'b0;
    repeat (4) tick;
    chk("full_valid", id_valid, 1);
    id_ready = 1'b1;
    redir(32'h200); chk("r0_en", o_en, 0);
    tick; chk("r1_valid", o_valid, 0);
    tick; chk("r2_valid", o_valid, 0);
    tick; chk("r3_valid", o_valid, 1); chk("r3_pc", o_pc, 32'h200);
    redir(32'hFFC);
    tick; chk("wrap_en", o_en, 1); chk("wrap_addr0", o_addr, 32'h3FF);
    tick; chk("wrap_addr1", o_addr, 32'h000);
    tick; chk("wrap_pc0", o_pc, 32'hFFC);
    tick; chk("wrap_pc1", o_pc, 32'h1000);
    repeat (3) tick;
    chk("mid_inflight", imem_en, 1);
    #2 rst = 1'b0;
    #1 chk_reset;
    @(negedge clk);
    rst = 1'b1;
    model_reset;
    tick; chk("rs_c0_en", o_en, 1);
    tick; chk("rs_c1_valid", o_valid, 0);
    tick; chk("rs_c2_pc", o_pc, 32'h84);
    repeat (800) begin
      id_ready = $urandom_range(3) != 0;
      redirect_valid = $urandom_range(19) == 0;
      redirect_pc = $urandom & (($urandom_range(3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      tick;
    end
    redirect_valid = 1'b0;
    id_ready = 1'b1;
`ifdef IF_MISALIGN_CHK_EN
    redir(32'h202);
    tick; chk("mis1_en", o_en, 0);
    tick; chk("mis2_valid", o_valid, 1); chk("mis2_pc", o_pc, 32'h202);
    chk("mis2_instr", o_instr, NOP_INSTR); chk("mis2_flag", o_mis, 1);
    repeat (5) begin tick; chk("mis_halt_en", o_en, 0); chk("mis_halt_valid", o_valid, 0); end
    redir(32'h300);
    tick; chk("res_en", o_en, 1); chk("res_addr", o_addr, 32'hC0);
    tick;
    tick; chk("res_pc", o_pc, 32'h300); chk("res_flag", o_mis, 0);
`else
    redir(32'h202);
    tick; chk("al_en", o_en, 1); chk("al_addr", o_addr, 32'h80);
    tick;
    tick; chk("al_pc", o_pc, 32'h200); chk("al_flag", o_mis, 0);
`endif
    repeat (4) tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/plcpu_fetch.md
# plcpu_fetch

Instruction-fetch front end for the pipelined CPU. It owns the program counter, issues word reads to the synchronous-read instruction memory, and buffers returned instructions in a small queue. It presents them to the decode stage over a valid/ready handshake and honours redirects (branch/jump/trap) from execute by flushing all younger fetched work.

## Interface
- IMEM_WORDS, 1024: instruction memory depth in 32-bit words; AW = $clog2(IMEM_WORDS)
- RESET_PC, 32'h0000_0084: PC of the first fetched instruction after reset
- QDEPTH, 2: instruction queue entries (≥2)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low (one clock; reset asserted when rst=0)
- imem_en  out  1  read request this cycle
- imem_addr  out  AW  word address = pc[AW+1:2]
- imem_rdata  in  32  instruction word, valid the cycle after imem_en
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  32  restart target
- id_valid  out  1  queue head valid
- id_ready  in  1  decode accepts head
- id_instr  out  32  head instruction
- id_pc  out  32  head PC
- id_misalign  out  1  head came from a misaligned redirect (see Configuration)

## Operation
- Registers: pc_q (next fetch PC), inflight_q (1 bit), inflight_pc_q, queue (pc, instr, misalign), count_q.
- Issue rule: imem_en=1 iff no redirect this cycle, fetch not halted, and count_q − pop + inflight_q < QDEPTH, where pop = id_valid & id_ready. On issue: imem_addr=pc_q[AW+1:2], pc_q += 4, inflight_q←1, inflight_pc_q←pc_q.
- Response: if inflight_q and not killed, the {inflight_pc_q, imem_rdata} entry is pushed at the end of that cycle. The issue rule guarantees the push never overflows.
- Head: id_valid = (count_q≠0); id_instr/id_pc/id_misalign come from the queue head. Pop occurs on id_valid & id_ready.
- Redirect (highest priority): pc_q←redirect_pc, queue emptied, any in-flight response discarded, imem_en=0 in the redirect cycle. A handshake occurring in the same cycle still counts as accepted; the queue is flushed regardless.
- Address wrap: PCs beyond IMEM_WORDS×4 wrap modulo the memory, using only pc bits [AW+1:2]. pc_q itself is a full 32-bit increment with natural 2^32 wrap.

## Timing
- Reset values: pc_q=RESET_PC, count_q=0, inflight_q=0. Outputs imem_en=0, imem_addr=RESET_PC[AW+1:2], id_valid=0, id_instr=0, id_pc=0, id_misalign=0.
- First cycle after rst deasserts (C0): imem_en=1, addr=0x21. C1: rdata captured. C2: id_valid=1, id_pc=0x84.
- Fetch-to-decode latency: 2 cycles. Redirect in cycle R: issue at R+1, id_valid for the target at R+3.
- Sustained throughput: 1 instruction/cycle with id_ready held high.
- Backpressure: no instruction is lost or duplicated. imem_en stays low while the queue plus in-flight count is full.
- rst asserted mid-operation: all state cleared immediately; in-flight data is ignored.

## Configuration
- IF_MISALIGN_CHK_EN defined: a redirect_pc with [1:0]≠0 produces exactly one queue entry with id_pc=redirect_pc, id_instr=32'h0000_0013 (NOP), id_misalign=1. No memory read is issued for it. Fetch then halts (imem_en=0) until the next redirect.
- Not defined: redirect_pc[1:0] is forced to 2'b00 and fetch continues normally; id_misalign is tied to 0.

## Structure
- Package plcpu_fetch_pkg: NOP_INSTR=32'h0000_0013, default RESET_PC, and the fetch_entry_t struct {pc[31:0], instr[31:0], misalign}.
- Sub-module plcpu_fetch_queue: parameterised QDEPTH FIFO of fetch_entry_t with push, pop, synchronous flush and a count output. Flush takes precedence over a same-cycle push.

## Test plan
- Reset release, id_ready=1, memory holds word i at address i → id_pc sequence 0x84, 0x88, 0x8C from C2 onward, one per cycle, with matching id_instr.
- id_ready=0 for 5 cycles starting at C3 → imem_en drops once 2 entries are held/in flight; after release the next id_pc values are consecutive, with no gap and no repeat.
- With the queue full, redirect_valid=1, redirect_pc=0x200 at cycle R → imem_en=0 at R, id_valid=0 at R+1 and R+2, id_pc=0x200 at R+3, and stale PCs never appear.
- Redirect to 0xFFC with IMEM_WORDS=1024 → imem_addr 0x3FF then 0x000, id_pc 0xFFC then 0x1000.
- rst pulsed low mid-stream with a read in flight → outputs reach reset values asynchronously, and the restart delivers id_pc=0x84 first.
- With IF_MISALIGN_CHK_EN, redirect to 0x202 → one entry {0x202, 0x13, misalign=1}, then imem_en stays 0 until redirect to 0x300 resumes fetch.
